// File: rtl/conv2d_pad_mac.sv
// K x K zero-padded 2D convolution: one tap read per cycle, signed MAC, one pixel write per output.
// Build option CONV2D_SATURATE_EN clamps results to [0, 2^DATA_W-1]; otherwise results wrap.
module conv2d_pad_mac #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int COEF_W = 8,
  parameter int K      = 3,
  parameter int DIM_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         rows,
  input  logic [DIM_W-1:0]         cols,
  input  logic                     coef_we,
  input  logic [5:0]               coef_idx,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic [DATA_W-1:0]        d_in,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        d_out,
  output logic                     busy,
  output logic                     ready
);
  localparam int P  = (K - 1) / 2;
  localparam int NT = K * K;
  localparam int KW = $clog2(K);
  localparam int TW = $clog2(NT);
  localparam int AW = DATA_W + COEF_W + 6;
  localparam int LW = 2 * DIM_W + 1;
  localparam logic signed [AW-1:0] PIX_MAX = {{(AW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic              scan, coef_open, launch, drain_q;
  logic [DIM_W-1:0]  rows_q, cols_q, r_q, c_q;
  logic [KW-1:0]     kr_q, kc_q;
  logic [TW-1:0]     tap_q;
  logic              wrap_kc, wrap_kr, wrap_c, wrap_r, last_px_tap, last_tap;
  logic signed [DIM_W:0] tr, tc;
  logic              tap_ok;
  logic [LW-1:0]     lin, plin;

  logic              s1_act_q, s1_vld_q, s1_first_q, s1_last_q;
  logic [TW-1:0]     s1_tap_q;
  logic [ADDR_W-1:0] s1_waddr_q;

  logic signed [COEF_W-1:0]        coef_q [NT];
  logic signed [COEF_W-1:0]        coef_sel;
  logic signed [DATA_W:0]          dz;
  logic signed [DATA_W+COEF_W:0]   prod;
  logic signed [AW-1:0]            prod_x, acc_q, acc_d;
  logic [DATA_W-1:0]               pix;
  logic                            wr_en_q;
  logic [ADDR_W-1:0]               wr_addr_q;
  logic [DATA_W-1:0]               d_out_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && rows != '0 && cols != '0) state_d = SCAN;
      SCAN:    if (last_tap) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    ready     = 1'b0;
    scan      = 1'b0;
    coef_open = 1'b0;
    unique case (state_q)
      IDLE:    coef_open = 1'b1;
      SCAN:    begin busy = 1'b1; scan = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    begin ready = 1'b1; coef_open = 1'b1; end
      default: ;
    endcase
  end

  assign launch      = (state_q == IDLE) && (state_d == SCAN);
  assign wrap_kc     = kc_q == KW'(K - 1);
  assign wrap_kr     = kr_q == KW'(K - 1);
  assign wrap_c      = c_q == cols_q - 1'b1;
  assign wrap_r      = r_q == rows_q - 1'b1;
  assign last_px_tap = wrap_kc && wrap_kr;
  assign last_tap    = last_px_tap && wrap_c && wrap_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q <= '0; cols_q <= '0; r_q <= '0; c_q <= '0;
      kr_q <= '0; kc_q <= '0; tap_q <= '0; drain_q <= 1'b0;
    end else begin
      drain_q <= (state_q == DRAIN);
      if (launch) begin
        rows_q <= rows; cols_q <= cols; r_q <= '0; c_q <= '0;
        kr_q <= '0; kc_q <= '0; tap_q <= '0;
      end else if (scan) begin
        tap_q <= last_px_tap ? '0 : tap_q + 1'b1;
        kc_q  <= wrap_kc ? '0 : kc_q + 1'b1;
        if (wrap_kc) kr_q <= wrap_kr ? '0 : kr_q + 1'b1;
        if (last_px_tap) begin
          c_q <= wrap_c ? '0 : c_q + 1'b1;
          if (wrap_c) r_q <= wrap_r ? '0 : r_q + 1'b1;
        end
      end
    end
  end

  // Coordinates beyond the signed range wrap negative, which still reads as padding.
  assign tr     = $signed((DIM_W+1)'(r_q) + (DIM_W+1)'(kr_q) - (DIM_W+1)'(P));
  assign tc     = $signed((DIM_W+1)'(c_q) + (DIM_W+1)'(kc_q) - (DIM_W+1)'(P));
  assign tap_ok = scan && !tr[DIM_W] && (tr[DIM_W-1:0] < rows_q)
                       && !tc[DIM_W] && (tc[DIM_W-1:0] < cols_q);
  assign lin    = LW'(tr[DIM_W-1:0]) * LW'(cols_q) + LW'(tc[DIM_W-1:0]);
  assign plin   = LW'(r_q) * LW'(cols_q) + LW'(c_q);
  assign rd_en   = tap_ok;
  assign rd_addr = tap_ok ? ADDR_W'(lin) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_act_q <= 1'b0; s1_vld_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      s1_tap_q <= '0; s1_waddr_q <= '0;
    end else begin
      s1_act_q   <= scan;
      s1_vld_q   <= tap_ok;
      s1_first_q <= tap_q == '0;
      s1_last_q  <= last_px_tap;
      s1_tap_q   <= tap_q;
      s1_waddr_q <= ADDR_W'(plin);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NT; i++) coef_q[i] <= '0;
    end else if (coef_we && coef_open && coef_idx < 6'(NT)) begin
      for (int unsigned i = 0; i < NT; i++)
        if (coef_idx == 6'(i)) coef_q[i] <= coef_in;
    end
  end

  always_comb begin
    coef_sel = '0;
    for (int unsigned i = 0; i < NT; i++)
      if (s1_tap_q == TW'(i)) coef_sel = coef_q[i];
  end

  assign dz     = $signed({1'b0, d_in});
  assign prod   = dz * coef_sel;
  assign prod_x = prod;

  always_comb begin
    acc_d = acc_q;
    if (s1_first_q) acc_d = '0;
    if (s1_vld_q)   acc_d = acc_d + prod_x;
  end

  always_comb begin
`ifdef CONV2D_SATURATE_EN
    if (acc_d < 0)            pix = '0;
    else if (acc_d > PIX_MAX) pix = '1;
    else                      pix = acc_d[DATA_W-1:0];
`else
    pix = acc_d[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0; wr_en_q <= 1'b0; wr_addr_q <= '0; d_out_q <= '0;
    end else begin
      wr_en_q <= s1_act_q && s1_last_q;
      if (s1_act_q) acc_q <= acc_d;
      if (s1_act_q && s1_last_q) begin
        wr_addr_q <= s1_waddr_q;
        d_out_q   <= pix;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign d_out   = d_out_q;
endmodule

// File: tb/tb_conv2d_pad_mac.sv
// Scoreboard bench for conv2d_pad_mac: a reference convolution predicts every write.
module tb_conv2d_pad_mac;
  localparam int ADDR_W = 17, DATA_W = 12, COEF_W = 8, K = 3, DIM_W = 8;
  localparam int NT = K * K;

  logic clk = 1'b0;
  logic rst, start, coef_we;
  logic [DIM_W-1:0] rows, cols;
  logic [5:0] coef_idx;
  logic signed [COEF_W-1:0] coef_in;
  logic [DATA_W-1:0] d_in = '0;
  logic rd_en, wr_en, busy, ready;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] d_out;

  conv2d_pad_mac #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEF_W(COEF_W), .K(K), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_in(coef_in), .d_in(d_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .d_out(d_out), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:1023];
  always @(posedge clk) if (rd_en) d_in <= mem[rd_addr[9:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  wr_t sbq[$];
  int coef_m [NT];
  int last_wr = -1;
  int trk_lo = -1, trk_hi = -1;
  int rdq[$];

  always @(negedge clk) begin
    if (rd_en && cyc >= trk_lo && cyc <= trk_hi) rdq.push_back(int'(rd_addr));
    if (wr_en) begin
      wr_t e;
      last_wr = cyc;
      if (sbq.size() == 0) chk("wr_extra", 32'(wr_en), 0);
      else begin
        e = sbq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("d_out", 32'(d_out), 32'(e.d));
      end
    end
  end

  function automatic logic [DATA_W-1:0] model_px(input int r, input int c, input int nr, input int nc);
    int acc;
    acc = 0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++) begin
        int tr, tc;
        tr = r + kr - (K - 1) / 2;
        tc = c + kc - (K - 1) / 2;
        if (tr >= 0 && tr < nr && tc >= 0 && tc < nc)
          acc += int'(mem[tr * nc + tc]) * coef_m[kr * K + kc];
      end
`ifdef CONV2D_SATURATE_EN
    if (acc < 0) acc = 0;
    if (acc > (1 << DATA_W) - 1) acc = (1 << DATA_W) - 1;
`endif
    return acc[DATA_W-1:0];
  endfunction

  task automatic set_coef(input int idx, input int val);
    coef_we = 1'b1; coef_idx = 6'(idx); coef_in = COEF_W'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (idx < NT) coef_m[idx] = val;
  endtask

  task automatic load_all(input int val);
    for (int i = 0; i < NT; i++) set_coef(i, val);
  endtask

  task automatic fill_mem(input int n, input int val, input bit rnd);
    for (int i = 0; i < n; i++) mem[i] = rnd ? DATA_W'($urandom) : DATA_W'(val);
  endtask

  task automatic push_frame(input int nr, input int nc);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        wr_t e;
        e.a = ADDR_W'(r * nc + c);
        e.d = model_px(r, c, nr, nc);
        sbq.push_back(e);
      end
  endtask

  task automatic run_frame(input int nr, input int nc, input bit disturb);
    int t, lim;
    push_frame(nr, nc);
    rdq.delete(); last_wr = -1;
    rows = DIM_W'(nr); cols = DIM_W'(nc); start = 1'b1;
    t = cyc; trk_lo = t + 1; trk_hi = t + NT;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 1);
    lim = nr * nc * NT + 20;
    while (!ready && cyc < t + lim) begin
      if (disturb && cyc == t + 5) begin
        coef_we = 1'b1; coef_idx = 6'd4; coef_in = 8'sd55; start = 1'b1;
      end
      @(negedge clk);
      coef_we = 1'b0; start = 1'b0;
    end
    chk("ready", 32'(ready), 1);
    chk("last_wr_lat", 32'(last_wr - t), 32'(nr * nc * NT + 2));
    chk("sb_left", 32'(sbq.size()), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_ack", 32'(ready), 0);
    chk("busy_ack", 32'(busy), 0);
  endtask

  task automatic zero_dim(input int nr, input int nc);
    int b, rr;
    b = 0; rr = 0;
    rows = DIM_W'(nr); cols = DIM_W'(nc); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b += int'(busy); rr += int'(rd_en);
      @(negedge clk);
    end
    chk("zero_busy", 32'(b), 0);
    chk("zero_rd", 32'(rr), 0);
  endtask

  task automatic abort_frame();
    int t, n;
    push_frame(5, 5);
    rows = 8'd5; cols = 8'd5; start = 1'b1; t = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_rd_addr", 32'(rd_addr), 0);
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_wr_addr", 32'(wr_addr), 0);
    chk("abort_d_out", 32'(d_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(ready), 0);
    chk("abort_writes_left", 32'(sbq.size()), 21);
    sbq.delete();
    for (int i = 0; i < NT; i++) coef_m[i] = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n += int'(busy) + int'(rd_en);
      @(negedge clk);
    end
    chk("abort_idle", 32'(n), 0);
  endtask

  initial begin
    int e4[4];
    e4 = '{0, 1, 5, 6};
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_in = '0;
    rows = '0; cols = '0;
    for (int i = 0; i < NT; i++) coef_m[i] = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_d_out", 32'(d_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // identity kernel over an address-valued image
    load_all(0); set_coef(4, 1);
    for (int i = 0; i < 25; i++) mem[i] = DATA_W'(i);
    run_frame(5, 5, 1'b0);

    // box filter on ones: padding counts, pixel 0 reads
    fill_mem(25, 1, 1'b0); load_all(1);
    run_frame(5, 5, 1'b0);
    chk("rd0_count", 32'(rdq.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("rd0_addr", (i < rdq.size()) ? 32'(rdq[i]) : 32'hFFFF_FFFF, 32'(e4[i]));

    // overflow and underflow handling
    fill_mem(25, 4095, 1'b0);
    run_frame(5, 5, 1'b0);
    load_all(0); set_coef(4, -1); fill_mem(25, 7, 1'b0);
    run_frame(5, 5, 1'b0);

    // random non-square frames; out-of-range index, and start/coef_we while scanning, ignored
    for (int i = 0; i < NT; i++) set_coef(i, int'($urandom_range(0, 255)) - 128);
    set_coef(12, 99);
    fill_mem(12, 0, 1'b1);
    run_frame(3, 4, 1'b1);
    fill_mem(8, 0, 1'b1);
    run_frame(4, 2, 1'b0);
    run_frame(1, 1, 1'b0);

    zero_dim(0, 5);
    zero_dim(5, 0);

    // mid-frame reset: coefficients clear, then fresh frames
    fill_mem(25, 0, 1'b1);
    abort_frame();
    run_frame(5, 5, 1'b0);
    for (int i = 0; i < NT; i++) set_coef(i, int'($urandom_range(0, 255)) - 128);
    run_frame(5, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
